// File: rtl/irq_priority_encoder_pkg.sv
// Shared types for the interrupt priority encoder: FSM state encoding and index-width helper.
package irq_prio_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic int idx_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/irq_priority_encoder_prio_pick.sv
// Combinational highest-set-bit finder; index is only meaningful when any=1.
module prio_pick #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 3
) (
  input  logic [WIDTH-1:0] vec,
  output logic             any,
  output logic [OUT_W-1:0] index
);

  always_comb begin
    any   = |vec;
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) index = OUT_W'(i);
    end
  end

endmodule

// File: rtl/irq_priority_encoder.sv
// Edge-latched interrupt collector presenting one winning index at a time with valid/ack.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; default build is fixed highest-index priority.
//
// state   | meaning
// IDLE    | nothing presented; grants the best eligible pending line on the next edge
// PRESENT | out_index/out_valid frozen until the consumer acks
module irq_priority_encoder
  import irq_prio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = idx_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             out_ack,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_index,
  output logic [WIDTH-1:0] pending_out,
  output logic             dropped
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] req_d;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] eligible;
  logic [WIDTH-1:0] pick_vec;
  logic             pick_any;
  logic [OUT_W-1:0] pick_idx;
  logic [OUT_W-1:0] winner;
  logic [OUT_W-1:0] index_d;
  logic             valid_d;
  state_t           state, state_d;

  assign rise        = req_in & ~req_d;
  assign clr         = (out_valid && out_ack) ? (ONE << out_index) : '0;
  assign eligible    = pending & ~mask_in;
  assign pending_out = pending;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [OUT_W-1:0] last_grant, last_grant_d;

  // Rotating right by last_grant puts line (last_grant-1) mod WIDTH at the top slot.
  always_comb begin
    pick_vec = '0;
    for (int j = 0; j < WIDTH; j++) begin
      pick_vec[j] = eligible[(j + int'(last_grant)) % WIDTH];
    end
    winner = OUT_W'((int'(pick_idx) + int'(last_grant)) % WIDTH);
  end
`else
  assign pick_vec = eligible;
  assign winner   = pick_idx;
`endif

  prio_pick #(
    .WIDTH(WIDTH),
    .OUT_W(OUT_W)
  ) u_pick (
    .vec  (pick_vec),
    .any  (pick_any),
    .index(pick_idx)
  );

  always_comb begin
    state_d = state;
    valid_d = out_valid;
    index_d = out_index;
`ifdef IRQ_ROUND_ROBIN_EN
    last_grant_d = last_grant;
`endif
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          index_d = winner;
        end
      end
      PRESENT: begin
        if (out_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
          last_grant_d = out_index;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_d     <= '0;
      pending   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      dropped   <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      last_grant <= '0;
`endif
    end else begin
      state     <= state_d;
      req_d     <= req_in;
      // Set wins over clear so an edge landing on the retiring line is not lost.
      pending   <= (pending & ~clr) | rise;
      out_valid <= valid_d;
      out_index <= index_d;
      dropped   <= |(rise & pending & ~clr);
`ifdef IRQ_ROUND_ROBIN_EN
      last_grant <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Self-checking bench for irq_priority_encoder: directed vector table, reset-mid-grant sequence, random vs model.
module tb_irq_priority_encoder;

  localparam int WIDTH = 8;
  localparam int OUT_W = 3;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] req_in;
  logic [WIDTH-1:0] mask_in;
  logic             out_ack;
  logic             out_valid;
  logic [OUT_W-1:0] out_index;
  logic [WIDTH-1:0] pending_out;
  logic             dropped;

  irq_priority_encoder #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_in     (req_in),
    .mask_in    (mask_in),
    .out_ack    (out_ack),
    .out_valid  (out_valid),
    .out_index  (out_index),
    .pending_out(pending_out),
    .dropped    (dropped)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Reference model: per-line bit arrays, priority scan in rotating order.
  bit m_pend[WIDTH];
  bit m_prev[WIDTH];
  bit m_valid;
  int m_idx;
  bit m_drop;
  int m_lg;

  function automatic void model_reset();
    for (int i = 0; i < WIDTH; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
    m_valid = 0;
    m_idx   = 0;
    m_drop  = 0;
    m_lg    = 0;
  endfunction

  function automatic logic [WIDTH-1:0] model_pend_vec();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic void model_step(logic [WIDTH-1:0] req, logic [WIDTH-1:0] mask, logic ack);
    int  clr_line;
    int  win;
    bit  drop;
    bit  new_pend[WIDTH];
    clr_line = (m_valid && ack) ? m_idx : -1;
    win = -1;
    for (int k = 0; k < WIDTH; k++) begin
      int i;
      i = (m_lg - 1 - k + 2 * WIDTH) % WIDTH;
      if (win < 0 && m_pend[i] && !mask[i]) win = i;
    end
    drop = 0;
    for (int i = 0; i < WIDTH; i++) begin
      bit r;
      r = req[i] && !m_prev[i];
      if (r && m_pend[i] && i != clr_line) drop = 1;
      new_pend[i] = (m_pend[i] && i != clr_line) || r;
    end
    for (int i = 0; i < WIDTH; i++) begin
      m_pend[i] = new_pend[i];
      m_prev[i] = req[i];
    end
    m_drop = drop;
    if (!m_valid) begin
      if (win >= 0) begin
        m_valid = 1;
        m_idx   = win;
      end
    end else if (ack) begin
      m_valid = 0;
`ifdef IRQ_ROUND_ROBIN_EN
      m_lg = m_idx;
`endif
    end
  endfunction

  task automatic check(string name, logic [WIDTH-1:0] e_pend, logic e_valid, int e_idx, logic e_drop);
    bit ok;
    checks++;
    ok = (pending_out === e_pend) && (out_valid === e_valid) && (dropped === e_drop) &&
         (!e_valid || out_index === OUT_W'(e_idx));
    if (ok) passes++;
    else $display("FAIL %s: got pend=%h valid=%b idx=%0d drop=%b, want pend=%h valid=%b idx=%0d drop=%b",
                  name, pending_out, out_valid, out_index, dropped, e_pend, e_valid, e_idx, e_drop);
  endtask

  task automatic check_zero(string name);
    checks++;
    if (pending_out === '0 && out_valid === 1'b0 && out_index === '0 && dropped === 1'b0) passes++;
    else $display("FAIL %s: got pend=%h valid=%b idx=%0d drop=%b, want all zero",
                  name, pending_out, out_valid, out_index, dropped);
  endtask

  // Drive inputs, advance one edge, step model, then settle before sampling.
  task automatic cycle(logic [WIDTH-1:0] req, logic [WIDTH-1:0] mask, logic ack);
    req_in  = req;
    mask_in = mask;
    out_ack = ack;
    @(posedge clock);
    model_step(req, mask, ack);
    #1;
  endtask

  typedef struct {
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] mask;
    logic             ack;
    logic [WIDTH-1:0] e_pend;
    logic             e_valid;
    int               e_idx;
    logic             e_drop;
  } vec_t;

  vec_t tbl[28];

  initial begin
    // single request on line 5
    tbl[0]  = '{8'h20, 8'h00, 0, 8'h20, 0, 0, 0};
    tbl[1]  = '{8'h00, 8'h00, 0, 8'h20, 1, 5, 0};
    tbl[2]  = '{8'h00, 8'h00, 1, 8'h00, 0, 0, 0};
    tbl[3]  = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0};
    // simultaneous 7 and 1
    tbl[4]  = '{8'h82, 8'h00, 0, 8'h82, 0, 0, 0};
    tbl[5]  = '{8'h00, 8'h00, 0, 8'h82, 1, 7, 0};
    tbl[6]  = '{8'h00, 8'h00, 1, 8'h02, 0, 0, 0};
    tbl[7]  = '{8'h00, 8'h00, 0, 8'h02, 1, 1, 0};
    tbl[8]  = '{8'h00, 8'h00, 1, 8'h00, 0, 0, 0};
    // mask holds idle, unmask grants, mask during PRESENT keeps the grant
    tbl[9]  = '{8'h40, 8'h40, 0, 8'h40, 0, 0, 0};
    tbl[10] = '{8'h00, 8'h40, 0, 8'h40, 0, 0, 0};
    tbl[11] = '{8'h00, 8'h40, 0, 8'h40, 0, 0, 0};
    tbl[12] = '{8'h00, 8'h00, 0, 8'h40, 1, 6, 0};
    tbl[13] = '{8'h00, 8'h40, 0, 8'h40, 1, 6, 0};
    tbl[14] = '{8'h00, 8'h40, 1, 8'h00, 0, 0, 0};
    tbl[15] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0};
    // drop on already-pending line 3
    tbl[16] = '{8'h08, 8'h00, 0, 8'h08, 0, 0, 0};
    tbl[17] = '{8'h00, 8'h00, 0, 8'h08, 1, 3, 0};
    tbl[18] = '{8'h08, 8'h00, 0, 8'h08, 1, 3, 1};
    tbl[19] = '{8'h00, 8'h00, 0, 8'h08, 1, 3, 0};
    tbl[20] = '{8'h00, 8'h00, 1, 8'h00, 0, 0, 0};
    tbl[21] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0};
    // ack collides with new rise on line 2
    tbl[22] = '{8'h04, 8'h00, 0, 8'h04, 0, 0, 0};
    tbl[23] = '{8'h00, 8'h00, 0, 8'h04, 1, 2, 0};
    tbl[24] = '{8'h04, 8'h00, 1, 8'h04, 0, 0, 0};
    tbl[25] = '{8'h00, 8'h00, 0, 8'h04, 1, 2, 0};
    tbl[26] = '{8'h00, 8'h00, 1, 8'h00, 0, 0, 0};
    tbl[27] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0};

    reset_n = 1'b0;
    req_in  = '0;
    mask_in = '0;
    out_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_state");
    @(negedge clock);
    reset_n = 1'b1;

    for (int n = 0; n < 28; n++) begin
      cycle(tbl[n].req, tbl[n].mask, tbl[n].ack);
      check($sformatf("vec%0d", n), tbl[n].e_pend, tbl[n].e_valid, tbl[n].e_idx, tbl[n].e_drop);
    end

    // reset while a grant is presented, line 0 held high across release
    cycle(8'h10, 8'h00, 0);
    cycle(8'h00, 8'h00, 0);
    check("pre_reset_grant", 8'h10, 1, 4, 0);
    req_in  = 8'h01;
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset_midgrant");
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cycle(8'h01, 8'h00, 0);
    check("held_line_after_reset", 8'h01, 0, 0, 0);
    cycle(8'h01, 8'h00, 0);
    check("held_line_granted", 8'h01, 1, 0, 0);
    cycle(8'h01, 8'h00, 1);
    check("held_line_no_relatch", 8'h00, 0, 0, 0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [WIDTH-1:0] r, m;
      logic a;
      r = WIDTH'($urandom & $urandom);
      m = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
      a = 1'($urandom_range(0, 1));
      cycle(r, m, a);
      check($sformatf("rand%0d", n), model_pend_vec(), m_valid, m_idx, m_drop);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
